// File: rtl/ecap5_dproc_pkg.sv
// ---------------------------------------------------------------------------
// ecap5_dproc_pkg
//   Shared constants and types for the processor front end.
//   NOP_INSTR      : canonical no-op (addi x0, x0, 0) presented on instr_o
//                    whenever no fetched word has been captured yet.
//   ifetch_state_t : fetch stage bus sequencing states.
// ---------------------------------------------------------------------------
package ecap5_dproc_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // S_REQ  : request presented on the bus (cyc=1, stb=1)
  // S_WAIT : request accepted, waiting for the acknowledge (cyc=1, stb=0)
  // S_HOLD : fetched word offered to decode, bus idle
  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } ifetch_state_t;

endpackage

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch
//   Instruction fetch stage. Keeps the program counter, fetches one 32-bit
//   word at a time over a pipelined Wishbone read port (at most one request
//   outstanding) and offers it to decode through a valid/ready handshake.
//   A branch redirects the PC and discards any fetch still in flight.
//
// Ports
//   clk_i            : clock, all state updates on the rising edge
//   rst_i            : synchronous reset, active low
//   branch_i         : redirect request from execute (beats everything else)
//   branch_target_i  : redirect target, bits [1:0] forced to 0
//   output_valid_o   : instr_o / pc_o hold a word for decode
//   output_ready_i   : decode accepts the word (low = decode stall)
//   instr_o, pc_o    : fetched instruction and its address
//   wb_adr_o         : Wishbone address (always the PC being fetched)
//   wb_dat_i         : Wishbone read data
//   wb_cyc_o/wb_stb_o: Wishbone cycle / strobe, decoded from the state
//   wb_stall_i       : Wishbone stall, request not taken this cycle
//   wb_ack_i         : Wishbone acknowledge
// ---------------------------------------------------------------------------
module ifetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        output_valid_o,
  input  logic        output_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i
);

  import ecap5_dproc_pkg::*;

  localparam logic [31:0] BOOT_PC = BOOT_ADDRESS & 32'hFFFF_FFFC;

  ifetch_state_t state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          discard_q, discard_d;
  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_out_q, pc_out_d;
  logic [31:0]   target;

  // Instructions are word aligned; the low target bits carry no meaning.
  assign target = branch_target_i & 32'hFFFF_FFFC;

  // ---------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its current value first so that no path
    // through the case leaves one unassigned (which would infer a latch).
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;

    unique case (state_q)
      S_REQ: begin
        if (branch_i) begin
          pc_d = target;
          // If the old address was taken this cycle its data must be
          // dropped; otherwise the new address simply replaces it.
          if (!wb_stall_i) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end else if (!wb_stall_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (branch_i) begin
          pc_d      = target;
          discard_d = 1'b1;
        end
        if (wb_ack_i) begin
          if (discard_q || branch_i) begin
            // Stale word: throw it away and fetch from the (new) PC.
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            instr_d  = wb_dat_i;
            pc_out_d = pc_q;
            pc_d     = pc_q + 32'd4;  // wraps modulo 2^32
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // A branch kills the offered word even if decode is not ready.
        if (branch_i) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = S_REQ;
        end else if (output_ready_i) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the values from before the edge, regardless of
    // statement order.
    if (!rst_i) begin
      state_q   <= S_REQ;
      pc_q      <= BOOT_PC;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      pc_out_q  <= BOOT_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. The bus strobes decode straight from the state; gating them
  // with rst_i drops an in-flight cycle the moment reset is applied.
  // ---------------------------------------------------------------------
  assign wb_cyc_o       = rst_i && ((state_q == S_REQ) || (state_q == S_WAIT));
  assign wb_stb_o       = rst_i && (state_q == S_REQ);
  assign wb_adr_o       = pc_q;
  assign output_valid_o = valid_q;
  assign instr_o        = instr_q;
  assign pc_o           = pc_out_q;

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch
//   Self-checking bench for ifetch. A Wishbone slave model returns a word
//   derived from the address with programmable stall and ack latency. The
//   reference model is the expected instruction stream: after reset or a
//   branch the next word delivered to decode must come from the start
//   address, and every later one from the previous address + 4. Expected
//   entries are queued by the stimulus side and popped by an independent
//   monitor whenever decode accepts a word.
// ---------------------------------------------------------------------------
module tb_ifetch;

  localparam logic [31:0] BOOT = 32'h0000_1000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        output_valid_o;
  logic        output_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_stall_i;
  logic        wb_ack_i;

  ifetch #(.BOOT_ADDRESS(BOOT)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .output_valid_o  (output_valid_o),
    .output_ready_i  (output_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .wb_adr_o        (wb_adr_o),
    .wb_dat_i        (wb_dat_i),
    .wb_cyc_o        (wb_cyc_o),
    .wb_stb_o        (wb_stb_o),
    .wb_stall_i      (wb_stall_i),
    .wb_ack_i        (wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: queue of words decode must receive, in order
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc = BOOT;

  function automatic void model_refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: next_pc, instr: mem_word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endfunction

  function automatic void model_restart(input logic [31:0] start);
    exp_q.delete();
    next_pc = start & 32'hFFFF_FFFC;
    model_refill();
  endfunction

  // ---------------------------------------------------------------------
  // Wishbone slave: evaluated at negedge+2, after the stimulus has settled
  // ---------------------------------------------------------------------
  int unsigned stall_pct   = 0;
  int unsigned lat_min     = 0;
  int unsigned lat_max     = 0;
  bit          force_stall = 1'b0;
  logic [31:0] pend_adr[$];
  int unsigned pend_wait[$];

  initial begin
    wb_stall_i = 1'b0;
    wb_ack_i   = 1'b0;
    wb_dat_i   = 32'h0;
    forever begin
      @(negedge clk_i);
      #2;
      wb_ack_i = 1'b0;
      wb_dat_i = 32'hDEAD_BEEF;
      if (pend_adr.size() > 0) begin
        if (pend_wait[0] == 0) begin
          wb_ack_i = 1'b1;
          wb_dat_i = mem_word(pend_adr[0]);
          void'(pend_adr.pop_front());
          void'(pend_wait.pop_front());
        end else begin
          pend_wait[0] = pend_wait[0] - 1;
        end
      end
      wb_stall_i = force_stall || ($urandom_range(99) < stall_pct);
      if (rst_i && wb_stb_o && !wb_stall_i) begin
        pend_adr.push_back(wb_adr_o);
        pend_wait.push_back($urandom_range(lat_max, lat_min));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Monitor: negedge+3, compares offered words against the model
  // ---------------------------------------------------------------------
  logic        prev_ok        = 1'b0;
  logic        prev_stall_req = 1'b0;
  logic [31:0] prev_adr       = 32'h0;

  initial begin
    forever begin
      @(negedge clk_i);
      #3;
      if (!rst_i) begin
        prev_ok = 1'b0;
      end else begin
        if (prev_ok && prev_stall_req) begin
          check("stb held under stall", {31'b0, wb_stb_o}, 32'd1);
          check("adr held under stall", wb_adr_o, prev_adr);
        end
        if (output_valid_o)
          check("bus idle while valid", {31'b0, wb_cyc_o}, 32'd0);
        if (output_valid_o && !branch_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream: got pc %h with no word expected", pc_o);
          end else begin
            check("stream pc_o", pc_o, exp_q[0].pc);
            check("stream instr_o", instr_o, exp_q[0].instr);
            if (output_ready_i) begin
              void'(exp_q.pop_front());
              n_accept++;
            end
          end
        end
        prev_stall_req = wb_stb_o && wb_stall_i && !branch_i;
        prev_adr       = wb_adr_o;
        prev_ok        = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: cyc() returns at the negedge drive point
  // ---------------------------------------------------------------------
  task automatic cyc();
    @(negedge clk_i);
    model_refill();
  endtask

  task automatic wait_valid(input string what);
    for (int i = 0; i < 60; i++) begin
      cyc();
      #4;
      if (output_valid_o) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s: output_valid_o stayed 0, required 1", what);
  endtask

  task automatic do_branch(input logic [31:0] tgt);
    cyc();
    branch_i        = 1'b1;
    branch_target_i = tgt;
    model_restart(tgt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  logic [31:0] held_pc, held_instr;
  int          acc0;
  logic        found;

  initial begin
    rst_i           = 1'b0;
    branch_i        = 1'b0;
    branch_target_i = 32'h0;
    output_ready_i  = 1'b1;

    // Reset state
    repeat (3) cyc();
    #4;
    check("reset valid", {31'b0, output_valid_o}, 32'd0);
    check("reset instr", instr_o, NOP);
    check("reset pc_o", pc_o, BOOT);
    check("reset cyc", {31'b0, wb_cyc_o}, 32'd0);
    check("reset stb", {31'b0, wb_stb_o}, 32'd0);
    check("reset adr", wb_adr_o, BOOT);

    // First fetch, zero-wait memory
    cyc();
    rst_i = 1'b1;
    model_restart(BOOT);
    #4;
    check("first adr", wb_adr_o, BOOT);
    check("first stb", {31'b0, wb_stb_o}, 32'd1);
    check("first valid low", {31'b0, output_valid_o}, 32'd0);
    cyc(); #4;
    check("wait stb low", {31'b0, wb_stb_o}, 32'd0);
    check("wait cyc high", {31'b0, wb_cyc_o}, 32'd1);
    check("wait valid low", {31'b0, output_valid_o}, 32'd0);
    cyc(); #4;
    check("first valid", {31'b0, output_valid_o}, 32'd1);
    check("first pc_o", pc_o, BOOT);
    check("first instr", instr_o, mem_word(BOOT));
    repeat (3) cyc();
    #4;
    check("second valid", {31'b0, output_valid_o}, 32'd1);
    check("second pc_o", pc_o, BOOT + 32'd4);

    // Throughput: one word per 3 cycles
    acc0 = n_accept;
    repeat (30) begin cyc(); #4; end
    check("throughput", n_accept - acc0, 32'd10);

    // Decode stall for 4 cycles
    cyc();
    output_ready_i = 1'b0;
    wait_valid("decode stall");
    held_pc    = pc_o;
    held_instr = instr_o;
    repeat (4) begin
      cyc(); #4;
      check("stall pc held", pc_o, held_pc);
      check("stall instr held", instr_o, held_instr);
      check("stall no cyc", {31'b0, wb_cyc_o}, 32'd0);
    end
    cyc();
    output_ready_i = 1'b1;
    // Bus stall for 3 cycles in S_REQ
    cyc();
    force_stall = 1'b1;
    #4;
    check("after stall adr", wb_adr_o, held_pc + 32'd4);
    check("after stall stb", {31'b0, wb_stb_o}, 32'd1);
    repeat (2) begin
      cyc(); #4;
      check("bus stall adr", wb_adr_o, held_pc + 32'd4);
      check("bus stall stb", {31'b0, wb_stb_o}, 32'd1);
    end
    cyc();
    force_stall = 1'b0;
    #4;
    check("stall released stb", {31'b0, wb_stb_o}, 32'd1);

    // Branch in S_WAIT in the same cycle as the ack
    do_branch(32'h0000_2002);
    #4;
    check("br+ack in wait stb", {31'b0, wb_stb_o}, 32'd0);
    check("br+ack in wait cyc", {31'b0, wb_cyc_o}, 32'd1);
    cyc();
    branch_i = 1'b0;
    #4;
    check("br+ack no valid", {31'b0, output_valid_o}, 32'd0);
    check("br+ack next adr", wb_adr_o, 32'h0000_2000);
    check("br+ack next stb", {31'b0, wb_stb_o}, 32'd1);
    cyc(); #4;
    cyc(); #4;
    check("br target valid", {31'b0, output_valid_o}, 32'd1);
    check("br target pc_o", pc_o, 32'h0000_2000);

    // Branch in S_WAIT, ack two cycles later
    lat_min = 2;
    lat_max = 2;
    cyc(); #4;
    check("late ack req adr", wb_adr_o, 32'h0000_2004);
    do_branch(32'h0000_3000);
    #4;
    cyc();
    branch_i = 1'b0;
    #4;
    check("late ack wait valid", {31'b0, output_valid_o}, 32'd0);
    cyc(); #4;
    check("late ack dropped", {31'b0, output_valid_o}, 32'd0);
    cyc(); #4;
    check("late ack refetch adr", wb_adr_o, 32'h0000_3000);
    check("late ack refetch stb", {31'b0, wb_stb_o}, 32'd1);
    lat_min = 0;
    lat_max = 0;
    wait_valid("late ack");
    check("late ack pc_o", pc_o, 32'h0000_3000);

    // Branch in S_HOLD while decode stalls
    cyc();
    output_ready_i = 1'b0;
    wait_valid("hold branch");
    do_branch(32'h0000_4008);
    #4;
    check("hold branch valid still", {31'b0, output_valid_o}, 32'd1);
    cyc();
    branch_i       = 1'b0;
    output_ready_i = 1'b1;
    #4;
    check("hold branch valid cleared", {31'b0, output_valid_o}, 32'd0);
    check("hold branch adr", wb_adr_o, 32'h0000_4008);
    wait_valid("hold branch target");
    check("hold branch pc_o", pc_o, 32'h0000_4008);

    // PC wrap
    do_branch(32'hFFFF_FFFC);
    cyc();
    branch_i = 1'b0;
    wait_valid("wrap");
    check("wrap pc_o", pc_o, 32'hFFFF_FFFC);
    cyc(); #4;
    check("wrap next adr", wb_adr_o, 32'h0000_0000);
    wait_valid("wrap next");
    check("wrap next pc_o", pc_o, 32'h0000_0000);

    // Reset in S_WAIT with a stray ack one cycle later
    lat_min = 1;
    lat_max = 1;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(); #4;
      found = wb_stb_o;
    end
    check("found request", {31'b0, found}, 32'd1);
    cyc();
    rst_i = 1'b0;
    #4;
    check("reset in wait cyc", {31'b0, wb_cyc_o}, 32'd0);
    check("reset in wait stb", {31'b0, wb_stb_o}, 32'd0);
    cyc();
    rst_i = 1'b1;
    model_restart(BOOT);
    #4;
    check("restart adr", wb_adr_o, BOOT);
    check("restart instr", instr_o, NOP);
    check("restart valid", {31'b0, output_valid_o}, 32'd0);
    cyc(); #4;
    check("stray ack ignored", {31'b0, output_valid_o}, 32'd0);
    cyc(); #4;
    check("restart wait", {31'b0, output_valid_o}, 32'd0);
    cyc(); #4;
    check("restart valid high", {31'b0, output_valid_o}, 32'd1);
    check("restart pc_o", pc_o, BOOT);
    check("restart instr_o", instr_o, mem_word(BOOT));

    // Randomized traffic
    stall_pct = 30;
    lat_min   = 0;
    lat_max   = 3;
    acc0      = n_accept;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      output_ready_i  = ($urandom_range(99) < 70);
      branch_target_i = $urandom;
      branch_i        = ($urandom_range(99) < 5);
      if (branch_i) begin
        if ($urandom_range(3) == 0)
          branch_target_i = 32'hFFFF_FFF0 | {28'b0, 4'($urandom)};
        model_restart(branch_target_i);
      end
    end
    cyc();
    branch_i       = 1'b0;
    output_ready_i = 1'b1;
    repeat (20) cyc();
    check("random traffic progressed", {31'b0, (n_accept - acc0) > 100}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage: generates the PC, fetches one instruction word at a time over a pipelined Wishbone read port, and hands the word to decode via a valid/ready handshake.
- Consumes the pipeline control signals:
  - output_ready_i is low while decode is stalled.
  - branch_i/branch_target_i redirect the PC and discard in-flight fetches.
- Sits between instruction memory and the decode stage.

Parameters:
BOOT_ADDRESS, 32'h00000000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  reset, synchronous, active-low (0 = reset)
branch_i  input  1  redirect request from execute
branch_target_i  input  32  redirect target; bits [1:0] ignored (forced 0)
output_valid_o  output  1  instr_o/pc_o valid for decode
output_ready_i  input  1  decode accepts (low = decode stall)
instr_o  output  32  fetched instruction
pc_o  output  32  address of instr_o
wb_adr_o  output  32  Wishbone address
wb_dat_i  input  32  Wishbone read data
wb_cyc_o  output  1  Wishbone cycle
wb_stb_o  output  1  Wishbone strobe
wb_stall_i  input  1  Wishbone stall (request not accepted)
wb_ack_i  input  1  Wishbone acknowledge

Behaviour:
- Reset (rst_i=0 at edge) sets:
  - state=S_REQ, pc_q=BOOT_ADDRESS, discard_q=0
  - output_valid_o=0, instr_o=32'h00000013 (NOP), pc_o=BOOT_ADDRESS
- Reset outputs for cyc/stb/adr:
  - wb_cyc_o and wb_stb_o are 0 while rst_i=0.
  - wb_adr_o=pc_q.
  - Reset mid-transaction abandons the bus cycle; stray acks are ignored outside S_WAIT.
- State machine; all outputs registered except wb_* which decode directly from state:
  - S_REQ: cyc=1, stb=1, adr=pc_q.
    - If branch_i: pc_q<=target. If wb_stall_i=0 (request accepted), also discard_q<=1 and go to S_WAIT; else stay in S_REQ (new address presented next cycle).
    - Else if wb_stall_i=0: go to S_WAIT.
  - S_WAIT: cyc=1, stb=0.
    - If branch_i: pc_q<=target, discard_q<=1.
    - On wb_ack_i with discard_q=1 or branch_i=1: drop data, discard_q<=0, go to S_REQ.
    - On wb_ack_i otherwise: instr_o<=wb_dat_i, pc_o<=pc_q, pc_q<=pc_q+4, output_valid_o<=1, go to S_HOLD.
  - S_HOLD: cyc=0, stb=0, output_valid_o=1; instr_o and pc_o stable.
    - If branch_i: output_valid_o<=0, pc_q<=target, go to S_REQ. Ignores output_ready_i.
    - Else if output_ready_i: output_valid_o<=0, go to S_REQ.
    - Else hold.
- Priority: branch_i beats handshake and ack in every state.
- Once a fetched word appears in instr_o it is never a discarded word.
- PC arithmetic: pc_q+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Latency and throughput:
  - Zero-wait memory gives first output_valid_o 3 cycles after reset release (REQ, WAIT with ack, then valid).
  - Steady state: one instruction per 3 cycles. At most one outstanding bus request.
- Timing of valid:
  - output_valid_o rises only on the edge leaving S_WAIT.
  - output_valid_o falls one edge after acceptance or branch.

Decomposition:
- ecap5_dproc_pkg:
  - NOP_INSTR constant (32'h00000013)
  - ifetch_state_t enum {S_REQ, S_WAIT, S_HOLD}
- No sub-module; single flat module.

Test Plan:
- Reset, BOOT_ADDRESS=0x1000, zero-wait memory, ready=1:
  - wb_adr_o=0x1000 on first cycle after release.
  - output_valid_o=1 with pc_o=0x1000 three cycles later.
  - Next word is pc_o=0x1004.
- Decode stall, output_ready_i=0 for 4 cycles while valid:
  - instr_o/pc_o held, no bus activity (cyc=0).
  - After ready=1, next request is to pc_o+4.
- wb_stall_i=1 for 3 cycles in S_REQ:
  - stb/adr held constant.
  - Transition to S_WAIT only after the stall drops.
- branch_i to 0x2002 in S_WAIT, same cycle as ack:
  - Data dropped, no valid.
  - Next wb_adr_o=0x2000.
  - Output pc_o=0x2000.
- branch_i in S_WAIT with ack arriving 2 cycles later:
  - Ack data discarded.
  - Next request to target.
- branch_i in S_HOLD with ready=0:
  - Valid cleared next cycle.
  - Fetch restarts at target.
- Wrap: pc_q=0xFFFFFFFC fetched → next wb_adr_o=0x00000000.
- Reset asserted in S_WAIT, ack 1 cycle later → ack ignored; restart at BOOT_ADDRESS.
